// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready register between CPU pipeline stages (IF/ID .. MEM/WB).
// Latency: push at edge N is visible on out_valid/out_data after edge N; no fall-through when empty.
// Backpressure: in_ready = !full (READY_PASS=0) or !full || out_ready (READY_PASS=1); flush squashes all entries.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset: empties the buffer and zeroes storage
//   flush      synchronous squash of every buffered entry; overrides push and pop
//   in_valid   upstream offers in_data
//   in_ready   buffer accepts in_data this cycle
//   in_data    opaque WIDTH-bit stage record from upstream
//   out_valid  head entry is valid
//   out_ready  downstream consumes the head entry this cycle
//   out_data   head entry payload (registered array read)
//   count      number of valid entries, 0..DEPTH
module pipe_stage_buf #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 2,
   parameter bit READY_PASS = 1'b0,
   localparam int CW        = $clog2(DEPTH + 1),
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    cnt_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past the array.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign full  = (cnt_q == DEPTH_C);
   assign empty = (cnt_q == '0);

   // With READY_PASS a full buffer still accepts when the head leaves in the
   // same cycle; this is the only combinational path through the block.
   assign in_ready  = !full || (READY_PASS && out_ready);
   assign out_valid = !empty;
   assign out_data  = mem[head];
   assign count     = cnt_q;

   // Handshakes seen during a flush cycle are not completed on either side.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            tail <= ptr_inc(tail);
         end
         if (pop) begin
            head <= ptr_inc(head);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   // Storage is zeroed on reset so out_data reads 0 while empty after reset;
   // flush leaves contents alone since the pointers alone define validity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[tail] <= in_data;
      end
   end

`ifndef SYNTHESIS
   // Occupancy can never exceed the array.
   assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= DEPTH_C);

   // A stalled head must stay put until consumed or squashed.
   assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && out_data == $past(out_data)));
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
`timescale 1ns/1ps
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  flush;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] in_data  [4];
   logic [31:0] out_data [4];
   logic [1:0]  c0, c1, c2;
   logic        c3;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          nxt;
   logic [31:0] exp_q [4][$];

   always #5 clk = ~clk;

   // u0: DEPTH=2 RP=0, u1: DEPTH=3 RP=0, u2: DEPTH=2 RP=1, u3: DEPTH=1 RP=0
   pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .READY_PASS(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .count(c0));
   pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .READY_PASS(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .count(c1));
   pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .READY_PASS(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
      .count(c2));
   pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .READY_PASS(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(flush[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
      .count(c3));

   function automatic logic [31:0] get_cnt(input int i);
      case (i)
         0:       return 32'(c0);
         1:       return 32'(c1);
         2:       return 32'(c2);
         default: return 32'(c3);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic idle_all();
      flush     = '0;
      in_valid  = '0;
      out_ready = '0;
      for (int i = 0; i < 4; i++) begin
         in_data[i] = '0;
      end
   endtask

   // Inputs change only 1ns after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word until accepted (bounded), recording it as expected output.
   task automatic offer(input int i, input logic [31:0] d, input logic ordy);
      bit done;
      done         = 1'b0;
      in_valid[i]  = 1'b1;
      in_data[i]   = d;
      out_ready[i] = ordy;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready[i]) begin
            done = 1'b1;
            exp_q[i].push_back(d);
         end
         tick();
      end
      chk("offer_accepted", 32'(done), 32'd1);
      in_valid[i] = 1'b0;
   endtask

   // Scoreboard monitor: pops on every completed output handshake and checks
   // the stable-hold rule for stalled heads.
   task automatic monitor();
      logic [3:0]  hold = '0;
      logic [31:0] hold_dat [4];
      logic [31:0] e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (rst_n && hold[i]) begin
               chk("hold_valid", 32'(out_valid[i]), 32'd1);
               chk("hold_data", out_data[i], hold_dat[i]);
            end
            if (rst_n && out_valid[i] && out_ready[i] && !flush[i]) begin
               chk("out_has_expected", 32'(exp_q[i].size() > 0), 32'd1);
               if (exp_q[i].size() > 0) begin
                  e = exp_q[i].pop_front();
                  chk("out_data_order", out_data[i], e);
               end
            end
            hold[i]     = rst_n && out_valid[i] && !out_ready[i] && !flush[i];
            hold_dat[i] = out_data[i];
         end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1;
      idle_all();
      fork
         monitor();
      join_none

      // ---- asynchronous reset assert, no clock edge in between
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
         chk("rst_count", get_cnt(i), 32'd0);
         chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
         chk("rst_out_data", out_data[i], 32'd0);
      end
      @(posedge clk);
      tick();
      rst_n = 1'b1;

      // ---- single transfer, DEPTH=2
      in_valid[0] = 1'b1; in_data[0] = 32'hDEADBEEF; out_ready[0] = 1'b0;
      @(negedge clk);
      chk("single_in_ready", 32'(in_ready[0]), 32'd1);
      exp_q[0].push_back(32'hDEADBEEF);
      tick();
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("single_out_valid", 32'(out_valid[0]), 32'd1);
      chk("single_out_data", out_data[0], 32'hDEADBEEF);
      chk("single_count", get_cnt(0), 32'd1);
      tick();
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      @(negedge clk);
      chk("single_drained", get_cnt(0), 32'd0);
      tick();

      // ---- back-pressure and full
      offer(0, 32'h1, 1'b0);
      offer(0, 32'h2, 1'b0);
      in_valid[0] = 1'b1; in_data[0] = 32'h3;
      @(negedge clk);
      chk("bp_count_full", get_cnt(0), 32'd2);
      chk("bp_in_ready_full", 32'(in_ready[0]), 32'd0);
      chk("bp_head", out_data[0], 32'h1);
      tick();
      @(negedge clk);
      chk("bp_in_ready_still", 32'(in_ready[0]), 32'd0);
      chk("bp_head_still", out_data[0], 32'h1);
      exp_q[0].push_back(32'h3);
      tick();
      out_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_full_pop", 32'(in_ready[0]), 32'd0);
      tick();
      @(negedge clk);
      chk("bp_in_ready_after_pop", 32'(in_ready[0]), 32'd1);
      chk("bp_count_after_pop", get_cnt(0), 32'd1);
      tick();
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_last_head", out_data[0], 32'h3);
      tick();
      out_ready[0] = 1'b0;

      // ---- streaming with wrap-around, DEPTH=3, out_ready toggling
      nxt = 0;
      for (int k = 0; k < 40 && (nxt < 10 || out_valid[1]); k++) begin
         out_ready[1] = k[0];
         in_valid[1]  = (nxt < 10);
         in_data[1]   = 32'(nxt);
         @(negedge clk);
         if (k == 5) begin
            chk("stream_count_full", get_cnt(1), 32'd3);
            chk("stream_in_ready_full", 32'(in_ready[1]), 32'd0);
         end
         if (in_valid[1] && in_ready[1]) begin
            exp_q[1].push_back(32'(nxt));
            nxt++;
         end
         tick();
      end
      in_valid[1] = 1'b0; out_ready[1] = 1'b0;
      chk("stream_all_pushed", 32'(nxt), 32'd10);

      // ---- simultaneous push/pop at full: u2 (READY_PASS=1) vs u0 (READY_PASS=0)
      in_valid[0] = 1'b1; in_valid[2] = 1'b1;
      in_data[0] = 32'hA; in_data[2] = 32'hA;
      @(negedge clk);
      chk("rp_push_a_u0", 32'(in_ready[0]), 32'd1);
      chk("rp_push_a_u2", 32'(in_ready[2]), 32'd1);
      exp_q[0].push_back(32'hA); exp_q[2].push_back(32'hA);
      tick();
      in_data[0] = 32'hB; in_data[2] = 32'hB;
      @(negedge clk);
      exp_q[0].push_back(32'hB); exp_q[2].push_back(32'hB);
      tick();
      in_data[0] = 32'hC; in_data[2] = 32'hC;
      out_ready[0] = 1'b1; out_ready[2] = 1'b1;
      @(negedge clk);
      chk("rp1_in_ready_full", 32'(in_ready[2]), 32'd1);
      chk("rp0_in_ready_full", 32'(in_ready[0]), 32'd0);
      exp_q[0].push_back(32'hC); exp_q[2].push_back(32'hC);
      tick();
      in_valid[2] = 1'b0;
      @(negedge clk);
      chk("rp1_count_stays", get_cnt(2), 32'd2);
      chk("rp0_count_after", get_cnt(0), 32'd1);
      chk("rp0_in_ready_next", 32'(in_ready[0]), 32'd1);
      tick();
      in_valid[0] = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      out_ready[0] = 1'b0; out_ready[2] = 1'b0;
      @(negedge clk);
      chk("rp0_drained", get_cnt(0), 32'd0);
      chk("rp1_drained", get_cnt(2), 32'd0);
      tick();

      // ---- flush priority on u0 and u2 (u2 would otherwise accept 0x55)
      in_valid[0] = 1'b1; in_valid[2] = 1'b1;
      in_data[0] = 32'h11; in_data[2] = 32'h11;
      @(negedge clk);
      exp_q[0].push_back(32'h11); exp_q[2].push_back(32'h11);
      tick();
      in_data[0] = 32'h22; in_data[2] = 32'h22;
      @(negedge clk);
      exp_q[0].push_back(32'h22); exp_q[2].push_back(32'h22);
      tick();
      flush[0] = 1'b1; flush[2] = 1'b1;
      in_data[0] = 32'h55; in_data[2] = 32'h55;
      out_ready[0] = 1'b1; out_ready[2] = 1'b1;
      @(negedge clk);
      chk("flush_cycle_out_valid", 32'(out_valid[0]), 32'd1);
      chk("flush_cycle_count", get_cnt(0), 32'd2);
      chk("flush_cycle_in_ready_rp1", 32'(in_ready[2]), 32'd1);
      tick();
      exp_q[0].delete(); exp_q[2].delete();
      flush[0] = 1'b0; flush[2] = 1'b0;
      in_valid[0] = 1'b0; in_valid[2] = 1'b0;
      out_ready[0] = 1'b0; out_ready[2] = 1'b0;
      @(negedge clk);
      chk("flush_count_u0", get_cnt(0), 32'd0);
      chk("flush_count_u2", get_cnt(2), 32'd0);
      chk("flush_out_valid_u0", 32'(out_valid[0]), 32'd0);
      chk("flush_out_valid_u2", 32'(out_valid[2]), 32'd0);
      tick();
      in_valid[0] = 1'b1; in_valid[2] = 1'b1;
      in_data[0] = 32'h66; in_data[2] = 32'h66;
      @(negedge clk);
      exp_q[0].push_back(32'h66); exp_q[2].push_back(32'h66);
      tick();
      in_valid[0] = 1'b0; in_valid[2] = 1'b0;
      @(negedge clk);
      chk("post_flush_data_u0", out_data[0], 32'h66);
      chk("post_flush_data_u2", out_data[2], 32'h66);
      chk("post_flush_count_u2", get_cnt(2), 32'd1);
      tick();
      out_ready[0] = 1'b1; out_ready[2] = 1'b1;
      tick();
      out_ready[0] = 1'b0; out_ready[2] = 1'b0;

      // ---- reset asserted mid-stream discards entries immediately
      in_valid[0] = 1'b1; in_data[0] = 32'h77;
      @(negedge clk);
      exp_q[0].push_back(32'h77);
      tick();
      in_valid[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
      chk("midrst_count", get_cnt(0), 32'd0);
      chk("midrst_out_data", out_data[0], 32'd0);
      chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      tick();
      rst_n = 1'b1;

      // ---- DEPTH=1, READY_PASS=0: transfers on alternating cycles
      nxt = 32'h100;
      in_valid[3] = 1'b1; out_ready[3] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data[3] = 32'(nxt);
         @(negedge clk);
         chk("d1_in_ready_pattern", 32'(in_ready[3]), (k % 2 == 0) ? 32'd1 : 32'd0);
         if (in_ready[3]) begin
            exp_q[3].push_back(32'(nxt));
            nxt++;
         end
         tick();
      end
      in_valid[3] = 1'b0;
      tick();
      tick();
      out_ready[3] = 1'b0;
      chk("d1_transfers", 32'(nxt), 32'h104);

      // ---- every expected word must have been emitted
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("scoreboard_drained", 32'(exp_q[i].size()), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline register that replaces fixed enable/flush stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque WIDTH-bit stage payload under a valid/ready handshake. The payload is a packed stage record or control word. Up to DEPTH entries are buffered so an upstream stage can keep issuing while downstream stalls. A synchronous flush squashes every in-flight entry, for branch mispredicts and jumps.

## Interface
- WIDTH, 32, payload width in bits; must be ≥1.
- DEPTH, 2, buffer entries; must be ≥1; need not be a power of two.
- READY_PASS, 0, 0: in_ready depends only on registered state; 1: in_ready also asserts when full and out_ready=1 (combinational path out_ready→in_ready).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  buffer accepts in_data this cycle.
- in_data  input  WIDTH  payload from upstream stage.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head this cycle.
- out_data  output  WIDTH  head entry payload.
- count  output  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: DEPTH×WIDTH circular array with head (read) and tail (write) pointers, and a count register.
- Pointers wrap from DEPTH-1 to 0 explicitly. Modulo-2^n wrap is not allowed.
- The following signals are defined for every cycle:
  - full = (count == DEPTH); empty = (count == 0).
  - in_ready = !full when READY_PASS=0.
  - in_ready = !full || out_ready when READY_PASS=1.
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
- Push writes in_data to mem[tail] and advances tail.
- Pop advances head.
- count update: count+1 on push only, count-1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle are legal at any occupancy, including full with READY_PASS=1.
- out_valid = !empty. out_data = mem[head] at all times.
- Flush has priority over everything else:
  - The next state is count=0, head=0, tail=0.
  - in_data is not written that cycle.
  - mem contents are untouched.
  - in_ready and out_valid still reflect the current state during the flush cycle. Neither side may treat a handshake in that cycle as completed.
- Payload is opaque; the block never inspects or modifies it.
- Stable-hold rule: while out_valid=1 and out_ready=0, out_data and out_valid must not change.

## Timing
- Reset (rst_n=0, asynchronous assert):
  - count=0, head=0, tail=0, all mem entries=0.
  - Outputs: out_valid=0, out_data=0, count=0.
  - in_ready=1, combinational from count.
- Reset deassertion takes effect at the next rising edge. A handshake on the first edge after release is legal.
- Latency: a push at edge N makes that entry visible at out_data/out_valid after edge N. There is no same-cycle fall-through when empty.
- Throughput: one transfer per cycle when DEPTH≥2, or when DEPTH=1 with READY_PASS=1. DEPTH=1 with READY_PASS=0 sustains one transfer every 2 cycles.
- Reset asserted mid-stream discards all entries immediately. Outputs go to their reset values without waiting for a clock edge.
- count, out_valid and out_data are glitch-free registered/array-read outputs. in_ready is combinational only when READY_PASS=1.

## Test plan
- Reset and single transfer (WIDTH=32, DEPTH=2):
  - Assert rst_n=0 mid-cycle; expect out_valid=0, count=0, in_ready=1 immediately.
  - After release, push 0xDEADBEEF with out_ready=0; expect out_valid=1, out_data=0xDEADBEEF, count=1 next cycle.
- Back-pressure and full:
  - With out_ready=0, push 0x1 then 0x2; expect count=2, in_ready=0.
  - A third in_valid with 0x3 is not accepted; out_data holds 0x1.
  - Raise out_ready; expect order 0x1, 0x2 on consecutive cycles, then 0x3.
- Streaming and wrap-around (DEPTH=3):
  - Push 0..9 with out_ready toggling every cycle; expect the output sequence 0..9 exactly, no loss or duplication.
  - Pointers wrap 2→0 at least three times.
- Simultaneous push/pop at full (DEPTH=2, READY_PASS=1):
  - Full with 0xA, 0xB, out_ready=1, push 0xC; expect in_ready=1 and count stays 2.
  - Output sequence 0xA, 0xB, 0xC.
  - With READY_PASS=0, the same stimulus gives in_ready=0, and 0xC is accepted the following cycle.
- Flush priority:
  - With count=2, assert flush together with in_valid=1 (0x55) and out_ready=1; expect count=0 and out_valid=0 next cycle.
  - 0x55 is never emitted; the next push 0x66 appears as out_data after one cycle.
- DEPTH=1, READY_PASS=0: continuous in_valid and out_ready=1; expect accepted transfers on alternating cycles, in_ready toggling 1,0,1,0.
